// File: rtl/hamming_parity_sequencer_pkg.sv
// Shared definitions for the Hamming parity sequencer.
// Contents:
//   state_t          - sequencer states (IDLE, SCAN, DONE)
//   MODE_ENC/CHK     - request mode encodings
//   hamming_pos(i)   - 1-indexed codeword position of data bit i
//   group_mask(k)    - data bits covered by parity group k
package hamming_pkg;

    // Widest data word the mask helper can describe.
    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // Data bit i occupies the i-th non-power-of-two position, counting from 1.
    function automatic int unsigned hamming_pos(input int unsigned i);
        int unsigned seen;
        int unsigned pos;
        seen = 0;
        pos  = 0;
        for (int unsigned q = 1; q <= 2 * MAX_W; q++) begin
            if (pos == 0 && (q & (q - 32'd1)) != 32'd0) begin
                if (seen == i) pos = q;
                seen++;
            end
        end
        return pos;
    endfunction

    // Bit i is set when bit k of the position of data bit i is set.
    function automatic logic [MAX_W-1:0] group_mask(input int unsigned k,
                                                    input int unsigned data_w = 8);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < data_w && ((hamming_pos(i) >> k) & 32'd1) != 32'd0) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_parity_sequencer_xor.sv
// peres_multi_xor: reduction XOR built as a cascade of Peres gates.
// Ports:
//   a       - operand bits
//   y       - XOR of all bits of a
//   garbage - Peres AND-side outputs (prefix parity & next bit); not functional
module peres_multi_xor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic             y,
    output logic [WIDTH-1:0] garbage
);

    logic [WIDTH-1:0] chain;

    assign chain[0]   = a[0];
    assign garbage[0] = 1'b0;

    // Each stage: Q = prefix ^ a[i], R = prefix & a[i] (C input tied to 0).
    for (genvar i = 1; i < WIDTH; i++) begin : g_stage
        assign chain[i]   = chain[i-1] ^ a[i];
        assign garbage[i] = chain[i-1] & a[i];
    end

    assign y = chain[WIDTH-1];

endmodule

// File: rtl/hamming_parity_sequencer.sv
// hamming_parity_sequencer: Hamming encoder/checker that shares one multi-XOR
// across the parity groups, computing one group per clock.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   in_valid/in_ready            - request handshake (ready only in IDLE)
//   in_mode, in_data, in_parity  - request: 0=encode, 1=check; data; received parity
//   out_valid/out_ready          - result handshake
//   out_mode, out_parity         - captured mode; parity (encode) or syndrome (check)
//   out_data                     - captured data (encode) or corrected data (check)
//   out_err, out_uncorr          - check-mode error / uncorrectable flags
//   busy                         - sequencer not in IDLE
module hamming_parity_sequencer
    import hamming_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PAR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PAR_W-1:0]  in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [PAR_W-1:0]  out_parity,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              out_uncorr,
    output logic              busy
);

    localparam int unsigned CW_W  = DATA_W + PAR_W;
    localparam int unsigned CNT_W = (PAR_W > 1) ? $clog2(PAR_W) : 1;

    if (2 ** PAR_W < DATA_W + PAR_W + 1) begin : g_bad_par_w
        $error("PAR_W too small for DATA_W");
    end

    // Constant group masks and data-bit positions.
    logic [DATA_W-1:0] mask  [PAR_W];
    logic [PAR_W-1:0]  pos_c [DATA_W];

    for (genvar k = 0; k < PAR_W; k++) begin : g_mask
        assign mask[k] = DATA_W'(group_mask(k, DATA_W));
    end
    for (genvar i = 0; i < DATA_W; i++) begin : g_pos
        assign pos_c[i] = PAR_W'(hamming_pos(i));
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PAR_W-1:0]    acc_q, acc_d;
    logic                mode_q, mode_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [PAR_W-1:0]    par_q, par_d;

    logic                in_ready_d, out_valid_d, out_mode_d, out_err_d, out_uncorr_d, busy_d;
    logic [PAR_W-1:0]    out_parity_d;
    logic [DATA_W-1:0]   out_data_d;

    // Shared parity unit; garbage outputs carry no information.
    logic                xor_bit;
    logic [DATA_W-1:0]   xor_garbage_unused;

    peres_multi_xor #(.WIDTH(DATA_W)) u_xor (
        .a       (data_q & mask[cnt_q]),
        .y       (xor_bit),
        .garbage (xor_garbage_unused)
    );

    // Final accumulator including the group being processed this cycle.
    logic [PAR_W-1:0]  acc_fin, syndrome;
    logic [DATA_W-1:0] corr_data;

    always_comb begin
        acc_fin        = acc_q;
        acc_fin[cnt_q] = xor_bit;
        syndrome       = (mode_q == MODE_CHK) ? (acc_fin ^ par_q) : acc_fin;
        corr_data      = data_q;
        if (mode_q == MODE_CHK) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
                if (syndrome == pos_c[i]) corr_data[i] = ~data_q[i];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mode_d       = mode_q;
        data_d       = data_q;
        par_d        = par_q;
        in_ready_d   = in_ready;
        out_valid_d  = out_valid;
        out_mode_d   = out_mode;
        out_parity_d = out_parity;
        out_data_d   = out_data;
        out_err_d    = out_err;
        out_uncorr_d = out_uncorr;
        busy_d       = busy;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d     = in_mode;
                    data_d     = in_data;
                    par_d      = in_parity;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = SCAN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            SCAN: begin
                acc_d = acc_fin;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PAR_W - 1)) begin
                    cnt_d        = '0;
                    state_d      = DONE;
                    out_valid_d  = 1'b1;
                    out_mode_d   = mode_q;
                    out_parity_d = syndrome;
                    out_data_d   = corr_data;
                    out_err_d    = (mode_q == MODE_CHK) && (syndrome != '0);
                    out_uncorr_d = (mode_q == MODE_CHK) && (32'(syndrome) > CW_W);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mode_q     <= 1'b0;
            data_q     <= '0;
            par_q      <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_mode   <= 1'b0;
            out_parity <= '0;
            out_data   <= '0;
            out_err    <= 1'b0;
            out_uncorr <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mode_q     <= mode_d;
            data_q     <= data_d;
            par_q      <= par_d;
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            out_mode   <= out_mode_d;
            out_parity <= out_parity_d;
            out_data   <= out_data_d;
            out_err    <= out_err_d;
            out_uncorr <= out_uncorr_d;
            busy       <= busy_d;
        end
    end

endmodule
